// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared state/owner encodings and data width for mem_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_REQ  = 2'd1,
        ARB_ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IF = 1'b0,
        ARB_OWNER_LS = 1'b1
    } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_grant.sv
// ============================================================================
// arb_grant : combinational IF/LS picker, one-hot or zero grant
// Config    : MEM_ARB_RR_EN selects round-robin, otherwise fixed LS > IF
// Revision  : 1.0
// ============================================================================
`default_nettype none

module arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic if_valid_i,
    input  logic ls_valid_i,
    input  logic rr_last_i,
    input  logic en_i,
    output logic grant_if_o,
    output logic grant_ls_o
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_if_o = 1'b0;
        grant_ls_o = 1'b0;
        if (en_i) begin
            if (if_valid_i && ls_valid_i) begin
                // Contention: hand the port to whoever did not win last time.
                if (rr_last_i == ARB_OWNER_IF) begin
                    grant_ls_o = 1'b1;
                end else begin
                    grant_if_o = 1'b1;
                end
            end else begin
                grant_if_o = if_valid_i;
                grant_ls_o = ls_valid_i;
            end
        end
    end
`else
    logic unused_rr_last;
    assign unused_rr_last = rr_last_i;

    always_comb begin
        grant_if_o = 1'b0;
        grant_ls_o = 1'b0;
        if (en_i) begin
            grant_ls_o = ls_valid_i;
            grant_if_o = if_valid_i && !ls_valid_i;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory port between IF (read) and LS (read/write),
//               one transaction outstanding, with response timeout abort
// Config      : MEM_ARB_RR_EN enables round-robin arbitration (rr_last state)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            arb_err
);

    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, owner_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            if_resp_valid_q, if_resp_valid_d;
    logic            ls_resp_valid_q, ls_resp_valid_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
    logic            err_q, err_d;

    logic            w_grant_if;
    logic            w_grant_ls;
    logic            w_rr_last;
    logic            w_done;
    logic [XLEN-1:0] w_resp_data;

`ifdef MEM_ARB_RR_EN
    logic rr_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= ARB_OWNER_IF;
        end else if (w_grant_if) begin
            rr_last_q <= ARB_OWNER_IF;
        end else if (w_grant_ls) begin
            rr_last_q <= ARB_OWNER_LS;
        end
    end

    assign w_rr_last = rr_last_q;
`else
    assign w_rr_last = ARB_OWNER_IF;
`endif

    arb_grant u_arb_grant (
        .if_valid_i (if_req_valid),
        .ls_valid_i (ls_req_valid),
        .rr_last_i  (w_rr_last),
        .en_i       (state_q == ARB_ST_IDLE),
        .grant_if_o (w_grant_if),
        .grant_ls_o (w_grant_ls)
    );

    // A real response beats a timeout landing in the same cycle; stores ack with 0.
    assign w_done      = mem_resp_valid || (cnt_q == C_TO_LAST);
    assign w_resp_data = (mem_resp_valid && !we_q) ? mem_rdata : '0;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        cnt_d           = cnt_q;
        if_resp_valid_d = 1'b0;
        ls_resp_valid_d = 1'b0;
        if_rdata_d      = if_rdata_q;
        ls_rdata_d      = ls_rdata_q;
        err_d           = 1'b0;
        case (state_q)
            ARB_ST_IDLE: begin
                if (w_grant_ls) begin
                    owner_d = ARB_OWNER_LS;
                    we_d    = ls_we;
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    wmask_d = ls_we ? ls_wmask : 8'h00;
                    state_d = ARB_ST_REQ;
                end else if (w_grant_if) begin
                    owner_d = ARB_OWNER_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    wmask_d = 8'h00;
                    state_d = ARB_ST_REQ;
                end
            end
            ARB_ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ARB_ST_RESP;
                end
            end
            ARB_ST_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (w_done) begin
                    if (owner_q == ARB_OWNER_LS) begin
                        ls_resp_valid_d = 1'b1;
                        ls_rdata_d      = w_resp_data;
                    end else begin
                        if_resp_valid_d = 1'b1;
                        if_rdata_d      = w_resp_data;
                    end
                    err_d   = !mem_resp_valid;
                    state_d = ARB_ST_IDLE;
                end
            end
            default: begin
                state_d = ARB_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ARB_ST_IDLE;
            owner_q         <= ARB_OWNER_IF;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= 8'h00;
            cnt_q           <= '0;
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            if_rdata_q      <= '0;
            ls_rdata_q      <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            cnt_q           <= cnt_d;
            if_resp_valid_q <= if_resp_valid_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            if_rdata_q      <= if_rdata_d;
            ls_rdata_q      <= ls_rdata_d;
            err_q           <= err_d;
        end
    end

    assign if_req_ready  = w_grant_if;
    assign ls_req_ready  = w_grant_ls;
    assign if_resp_valid = if_resp_valid_q;
    assign if_rdata      = if_rdata_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_rdata      = ls_rdata_q;
    assign mem_req_valid = (state_q == ARB_ST_REQ);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = we_q ? wmask_q : 8'h00;
    assign arb_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter with a behavioural model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req_valid, if_req_ready, if_resp_valid;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            ls_req_valid, ls_req_ready, ls_we, ls_resp_valid;
    logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]      ls_wmask, mem_wmask;
    logic            mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, arb_err;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: who won the last grant (0 = IF, 1 = LS) and the held rdata values.
    bit              m_last_ls = 1'b0;
    logic [XLEN-1:0] m_if_d = '0;
    logic [XLEN-1:0] m_ls_d = '0;

    function automatic bit model_pick_ls(bit ifv, bit lsv, bit last_ls);
`ifdef MEM_ARB_RR_EN
        if (ifv && lsv) return !last_ls;
`endif
        return lsv;
    endfunction

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid = 0; if_addr = '0;
        ls_req_valid = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    // Presents a request in IDLE, samples the readies, and advances into REQ.
    task automatic issue(input bit ifv, input bit lsv, input bit we,
                         input logic [XLEN-1:0] ia, input logic [XLEN-1:0] la,
                         input logic [XLEN-1:0] wd, input logic [7:0] wm,
                         output bit r_if, output bit r_ls, output bit exp_ls);
        exp_ls = model_pick_ls(ifv, lsv, m_last_ls);
        m_last_ls = exp_ls;
        if_req_valid = ifv; if_addr = ia;
        ls_req_valid = lsv; ls_we = we; ls_addr = la; ls_wdata = wd; ls_wmask = wm;
        #1;
        r_if = if_req_ready;
        r_ls = ls_req_ready;
        tick();
        if_req_valid = 0;
        ls_req_valid = 0;
    endtask

    // Memory side: stalls the accept, answers on RESP cycle resp_dly (0 = never),
    // and captures the response pulse.
    task automatic serve(input int rdy_dly, input int resp_dly, input logic [XLEN-1:0] rd,
                         output bit stable, output bit g_if, output bit g_ls, output bit g_err,
                         output logic [XLEN-1:0] d_if, output logic [XLEN-1:0] d_ls,
                         output int cyc, output bit one_cycle);
        logic            s_we;
        logic [XLEN-1:0] s_addr, s_wdata;
        logic [7:0]      s_wmask;
        s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_wmask = mem_wmask;
        stable = mem_req_valid;
        for (int i = 0; i < rdy_dly; i++) begin
            mem_req_ready = 0;
            tick();
            if (!mem_req_valid || mem_we !== s_we || mem_addr !== s_addr ||
                mem_wdata !== s_wdata || mem_wmask !== s_wmask) stable = 0;
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        g_if = 0; g_ls = 0; g_err = 0; d_if = '0; d_ls = '0; cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            mem_resp_valid = (c == resp_dly);
            mem_rdata      = rd;
            tick();
            mem_resp_valid = 0;
            if (if_resp_valid || ls_resp_valid || arb_err) begin
                g_if = if_resp_valid; g_ls = ls_resp_valid; g_err = arb_err;
                d_if = if_rdata; d_ls = ls_rdata; cyc = c;
                break;
            end
        end
        tick();
        one_cycle = !(if_resp_valid || ls_resp_valid || arb_err);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        tick(); tick();
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        n_total++; if ({if_resp_valid, ls_resp_valid, arb_err} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {if_resp_valid, ls_resp_valid, arb_err}); else n_pass++;
        n_total++; if (if_rdata !== '0 || ls_rdata !== '0) $display("FAIL reset_rdata: got %h/%h want 0", if_rdata, ls_rdata); else n_pass++;
        n_total++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== 8'h00 || mem_we !== 1'b0) $display("FAIL reset_mem_fields: got addr %h wdata %h wmask %h we %b want 0", mem_addr, mem_wdata, mem_wmask, mem_we); else n_pass++;
        rst = 1;
        m_last_ls = 0; m_if_d = '0; m_ls_d = '0;
        tick();
        n_total++; if ({if_req_ready, ls_req_ready, mem_req_valid} !== 3'b000) $display("FAIL reset_idle_ready: got %b want 000", {if_req_ready, ls_req_ready, mem_req_valid}); else n_pass++;
    endtask

    task automatic test_if_read();
        bit r_if, r_ls, e_ls, st, g_if, g_ls, g_err, one;
        logic [XLEN-1:0] d_if, d_ls;
        int cyc;
        issue(1, 0, 0, 64'h8000_0000, '0, '0, 8'h00, r_if, r_ls, e_ls);
        n_total++; if ({r_if, r_ls} !== 2'b10) $display("FAIL if_read_ready: got %b want 10", {r_if, r_ls}); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_we !== 1'b0) $display("FAIL if_read_req: got v %b addr %h we %b want 1 80000000 0", mem_req_valid, mem_addr, mem_we); else n_pass++;
        n_total++; if (mem_wmask !== 8'h00) $display("FAIL if_read_wmask: got %h want 00", mem_wmask); else n_pass++;
        serve(0, 2, 64'h13, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
        m_if_d = 64'h13;
        n_total++; if ({g_if, g_ls, g_err} !== 3'b100) $display("FAIL if_read_pulse: got %b want 100", {g_if, g_ls, g_err}); else n_pass++;
        n_total++; if (d_if !== 64'h13) $display("FAIL if_read_rdata: got %h want 13", d_if); else n_pass++;
        n_total++; if (cyc !== 2 || one !== 1'b1) $display("FAIL if_read_timing: got cyc %0d single %b want 2 1", cyc, one); else n_pass++;
    endtask

    task automatic test_priority();
        bit r_if, r_ls, e_ls, st, g_if, g_ls, g_err, one, first_ls;
        logic [XLEN-1:0] d_if, d_ls, rd;
        int cyc;
        for (int round = 0; round < 2; round++) begin
            rd = rnd64();
            issue(1, 1, 0, 64'h100 + 64'(round), 64'h200 + 64'(round), '0, 8'hFF, r_if, r_ls, e_ls);
            first_ls = e_ls;
            n_total++; if ({r_ls, r_if} !== {e_ls, !e_ls}) $display("FAIL prio_first_grant: got ls/if %b%b want %b%b", r_ls, r_if, e_ls, !e_ls); else n_pass++;
            serve(0, 1, rd, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
            n_total++; if (g_ls !== e_ls || g_if !== !e_ls) $display("FAIL prio_first_owner: got ls/if %b%b want %b%b", g_ls, g_if, e_ls, !e_ls); else n_pass++;
            if (e_ls) m_ls_d = rd; else m_if_d = rd;
            issue(first_ls, !first_ls, 0, 64'h300, 64'h400, '0, 8'h00, r_if, r_ls, e_ls);
            n_total++; if ({r_ls, r_if} !== {!first_ls, first_ls}) $display("FAIL prio_second_grant: got ls/if %b%b want %b%b", r_ls, r_if, !first_ls, first_ls); else n_pass++;
            rd = rnd64();
            serve(0, 1, rd, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
            if (e_ls) m_ls_d = rd; else m_if_d = rd;
            n_total++; if ((e_ls ? d_ls : d_if) !== rd) $display("FAIL prio_second_rdata: got %h want %h", e_ls ? d_ls : d_if, rd); else n_pass++;
        end
    endtask

    task automatic test_store_stall();
        bit r_if, r_ls, e_ls, st, g_if, g_ls, g_err, one;
        logic [XLEN-1:0] d_if, d_ls;
        int cyc;
        issue(0, 1, 1, '0, 64'h8000_1000, 64'hAB, 8'h01, r_if, r_ls, e_ls);
        n_total++; if (r_ls !== 1'b1) $display("FAIL store_ready: got %b want 1", r_ls); else n_pass++;
        n_total++; if (mem_we !== 1'b1 || mem_addr !== 64'h8000_1000 || mem_wdata !== 64'hAB || mem_wmask !== 8'h01) $display("FAIL store_fields: got we %b addr %h wdata %h wmask %h", mem_we, mem_addr, mem_wdata, mem_wmask); else n_pass++;
        serve(4, 2, 64'hDEAD_BEEF, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
        m_ls_d = '0;
        n_total++; if (st !== 1'b1) $display("FAIL store_stable: got %b want 1", st); else n_pass++;
        n_total++; if ({g_if, g_ls, g_err} !== 3'b010 || d_ls !== '0) $display("FAIL store_ack: got pulses %b rdata %h want 010 0", {g_if, g_ls, g_err}, d_ls); else n_pass++;
    endtask

    task automatic test_timeout();
        bit r_if, r_ls, e_ls, st, g_if, g_ls, g_err, one;
        logic [XLEN-1:0] d_if, d_ls, rd;
        int cyc;
        issue(1, 0, 0, 64'h8000_0040, '0, '0, 8'h00, r_if, r_ls, e_ls);
        serve(0, 0, 64'h55, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
        m_if_d = '0;
        n_total++; if ({g_if, g_ls, g_err} !== 3'b101) $display("FAIL timeout_pulses: got %b want 101", {g_if, g_ls, g_err}); else n_pass++;
        n_total++; if (d_if !== '0 || cyc !== TO) $display("FAIL timeout_value: got rdata %h cyc %0d want 0 %0d", d_if, cyc, TO); else n_pass++;
        n_total++; if (one !== 1'b1 || mem_req_valid !== 1'b0) $display("FAIL timeout_idle: got single %b reqv %b want 1 0", one, mem_req_valid); else n_pass++;
        rd = rnd64();
        issue(0, 1, 0, '0, 64'h8000_0080, '0, 8'hFF, r_if, r_ls, e_ls);
        serve(0, TO, rd, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
        m_ls_d = rd;
        n_total++; if ({g_if, g_ls, g_err} !== 3'b010 || d_ls !== rd) $display("FAIL timeout_edge_resp: got %b rdata %h want 010 %h", {g_if, g_ls, g_err}, d_ls, rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit r_if, r_ls, e_ls;
        issue(0, 1, 0, '0, 64'h8000_2000, '0, 8'h00, r_if, r_ls, e_ls);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        tick();
        rst = 0;
        #1;
        n_total++; if ({mem_req_valid, ls_resp_valid, if_resp_valid, arb_err} !== 4'b0000) $display("FAIL rstmid_valids: got %b want 0000", {mem_req_valid, ls_resp_valid, if_resp_valid, arb_err}); else n_pass++;
        n_total++; if (ls_rdata !== '0 || if_rdata !== '0 || mem_addr !== '0) $display("FAIL rstmid_data: got ls %h if %h addr %h want 0", ls_rdata, if_rdata, mem_addr); else n_pass++;
        tick();
        rst = 1;
        m_last_ls = 0; m_if_d = '0; m_ls_d = '0;
        mem_resp_valid = 1;
        mem_rdata = 64'h1234;
        tick();
        mem_resp_valid = 0;
        tick();
        n_total++; if ({ls_resp_valid, if_resp_valid, arb_err, mem_req_valid} !== 4'b0000) $display("FAIL rstmid_stray: got %b want 0000", {ls_resp_valid, if_resp_valid, arb_err, mem_req_valid}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] aq[$];
        logic [XLEN-1:0] dq[$];
        logic [XLEN-1:0] exp;
        bit pend = 0, acc;
        int grants = 0, resps = 0, prev = -1;
        for (int i = 0; i < 40; i++) begin
            if_req_valid   = (i < 30);
            if_addr        = rnd64();
            mem_req_ready  = 1;
            mem_resp_valid = pend;
            mem_rdata      = rnd64();
            if (pend) dq.push_back(mem_rdata);
            #1;
            if (if_req_ready) begin
                aq.push_back(if_addr);
                if (prev >= 0) begin
                    n_total++; if (i - prev !== 3) $display("FAIL b2b_spacing: got %0d want 3", i - prev); else n_pass++;
                end
                prev = i;
                grants++;
                m_last_ls = 0;
            end
            acc = mem_req_valid;
            if (acc) begin
                exp = (aq.size() > 0) ? aq.pop_front() : '0;
                n_total++; if (mem_addr !== exp) $display("FAIL b2b_addr: got %h want %h", mem_addr, exp); else n_pass++;
            end
            tick();
            pend = acc;
            if (if_resp_valid) begin
                resps++;
                exp = (dq.size() > 0) ? dq.pop_front() : ~if_rdata;
                m_if_d = exp;
                n_total++; if (if_rdata !== exp) $display("FAIL b2b_rdata: got %h want %h", if_rdata, exp); else n_pass++;
            end
        end
        clear_inputs();
        tick();
        n_total++; if (grants !== 10 || resps !== grants) $display("FAIL b2b_count: got grants %0d resps %0d want 10 10", grants, resps); else n_pass++;
    endtask

    task automatic test_random();
        bit r_if, r_ls, e_ls, st, g_if, g_ls, g_err, one, ifv, lsv, we, e_to;
        logic [XLEN-1:0] d_if, d_ls, rd, ia, la, wd, e_d;
        logic [7:0] wm;
        int cyc, pat, rdy, rsp;
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(1, 3);
            ifv = pat[0]; lsv = pat[1];
            we = 1'($urandom); ia = rnd64(); la = rnd64(); wd = rnd64(); wm = 8'($urandom);
            rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 6); rd = rnd64();
            issue(ifv, lsv, we, ia, la, wd, wm, r_if, r_ls, e_ls);
            n_total++; if ({r_ls, r_if} !== {e_ls, !e_ls}) $display("FAIL rnd_grant: got ls/if %b%b want %b%b", r_ls, r_if, e_ls, !e_ls); else n_pass++;
            n_total++;
            if (mem_addr !== (e_ls ? la : ia) || mem_we !== (e_ls & we) || mem_wmask !== ((e_ls && we) ? wm : 8'h00) || (e_ls && we && mem_wdata !== wd))
                $display("FAIL rnd_fields: got addr %h we %b wmask %h wdata %h", mem_addr, mem_we, mem_wmask, mem_wdata);
            else n_pass++;
            serve(rdy, rsp, rd, st, g_if, g_ls, g_err, d_if, d_ls, cyc, one);
            e_to = (rsp == 0 || rsp > TO);
            e_d  = (e_to || (e_ls && we)) ? '0 : rd;
            if (e_ls) m_ls_d = e_d; else m_if_d = e_d;
            n_total++; if ({g_ls, g_if, g_err} !== {e_ls, !e_ls, e_to}) $display("FAIL rnd_pulses: got ls/if/err %b%b%b want %b%b%b", g_ls, g_if, g_err, e_ls, !e_ls, e_to); else n_pass++;
            n_total++; if (d_if !== m_if_d || d_ls !== m_ls_d) $display("FAIL rnd_rdata: got if %h ls %h want %h %h", d_if, d_ls, m_if_d, m_ls_d); else n_pass++;
            n_total++; if (cyc !== (e_to ? TO : rsp) || st !== 1'b1 || one !== 1'b1) $display("FAIL rnd_timing: got cyc %0d stable %b single %b", cyc, st, one); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_store_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
